simon_playback_sequencer: RTL
=============================

Name: simon_playback_sequencer

Overview:
- Paces pattern-memory playback for the Simon game so that each stored entry is visible on the pattern LEDs for a human-readable time.
- Sits between the Simon control FSM and the pattern memory. The control FSM issues a start pulse; this block walks addresses 0..count-1 and returns a done pulse.
- Owns the memory read port and the display drive during playback.

Parameters:
- ADDR_W, 4, width of memory address and of the count input.
- DATA_W, 4, width of one pattern entry (one bit per colour LED).
- ON_CYCLES, 12500000, cycles each entry is shown; must be >= 1.
- OFF_CYCLES, 2500000, blank cycles between entries; 0 allowed, which skips the gap.
- TIMER_W, 24, width of the dwell timer; must hold max(ON_CYCLES, OFF_CYCLES).

Ports:
- clk  in  1  clock
- rst  in  1  reset: synchronous, active-high
- start  in  1  single-cycle request to play entries 0..count-1; honoured only in IDLE
- abort  in  1  stop playback immediately and return to IDLE
- count  in  ADDR_W  number of valid entries; sampled on an accepted start
- mem_rd_en  out  1  memory read strobe
- mem_addr  out  ADDR_W  memory read address
- mem_rd_data  in  DATA_W  memory read data; valid exactly one cycle after mem_rd_en
- display_leds  out  DATA_W  pattern LED drive
- busy  out  1  high in every state except IDLE
- done  out  1  single-cycle pulse when a playback completes normally

Behaviour:
- Reset values:
  - state is IDLE.
  - index, timer, count_q and pattern_q are 0.
  - All outputs are 0.
- States: IDLE, FETCH, WAIT, SHOW, GAP, FINISH.
- IDLE:
  - start with count != 0 latches count_q <= count, clears index, and goes to FETCH.
  - start with count == 0 goes to FINISH without any memory read.
- FETCH (1 cycle): mem_rd_en = 1, mem_addr = index. Then go to WAIT.
- WAIT (1 cycle): latch pattern_q <= mem_rd_data at the end of the cycle, load timer = ON_CYCLES-1, go to SHOW.
- SHOW:
  - display_leds = pattern_q.
  - The timer decrements each cycle.
  - At timer == 0: if OFF_CYCLES > 0, load timer = OFF_CYCLES-1 and go to GAP; otherwise take the advance step.
- GAP: display_leds = 0; the timer decrements; at timer == 0 take the advance step.
- Advance step:
  - If index+1 == count_q, go to FINISH.
  - Otherwise index <= index+1 and go to FETCH.
- FINISH (1 cycle): done = 1, then go to IDLE.
- Per-entry period: 2 + ON_CYCLES + OFF_CYCLES cycles.
- Latency: done asserts 1 cycle after the last cycle of the final SHOW/GAP.
- Output rules:
  - display_leds is 0 in every state except SHOW.
  - mem_addr = index in all states; it is only meaningful while mem_rd_en is high.
- Arithmetic: index compare uses ADDR_W+1 bits, so count_q = 2^ADDR_W-1 and a full address space do not wrap.
- start while busy: ignored, no effect on state or count_q.
- abort: in any non-IDLE state, the next state is IDLE, display is cleared, and done is not pulsed. abort has priority over start in the same cycle. abort in IDLE is a no-op.
- count changing mid-playback: has no effect, since only count_q is used.
- rst mid-playback: returns all registers to reset values on the next edge, with no done pulse.

Decomposition:
- Shared package simon_pkg holds:
  - the playback state encoding (3-bit enum);
  - the DATA_W/ADDR_W defaults;
  - the LED mode constants already used by the Simon controller.
- One sub-module, simon_dwell_timer: loadable down-counter with ports load, load_value, and a zero flag. It is instantiated once and used for both SHOW and GAP.

Test Plan (ON_CYCLES=3, OFF_CYCLES=2; start sampled at cycle 0):
- count=3, memory = {4'b0001, 4'b0100, 4'b1000}, start:
  - mem_rd_en high at cycles 1, 8, 15 with addr 0, 1, 2.
  - display_leds = 0001 for cycles 3-5, 0100 for 10-12, 1000 for 17-19.
  - done high at cycle 22 only; busy high for cycles 1-22.
- count=0, start: no mem_rd_en; done high at cycle 1; display stays 0.
- count=2, start, abort at cycle 4 (during first SHOW): state IDLE at cycle 5, display 0, busy 0, no done.
  - A fresh start then replays from addr 0.
- Second start at cycle 5 of a count=2 playback, with count changed to 7 concurrently: ignored; exactly 2 entries play and done occurs at cycle 15.
- OFF_CYCLES=0 build, count=2: entries are shown back to back; the second FETCH is at cycle 6 and done is at cycle 11.
- rst asserted at cycle 9 of a count=3 playback: all outputs 0 at cycle 10, no done; the next start behaves as in scenario 1.

Source files
------------

// File: rtl/simon_pkg.sv
// Shared Simon game definitions: default widths, playback state encoding
// and the LED mode constants used by the Simon controller.
package simon_pkg;

    localparam int unsigned SIMON_ADDR_W = 4;
    localparam int unsigned SIMON_DATA_W = 4;

    // Pattern-playback sequencer states.
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_WAIT   = 3'd2,
        ST_SHOW   = 3'd3,
        ST_GAP    = 3'd4,
        ST_FINISH = 3'd5
    } play_state_e;

    // LED mode select used by the Simon controller's display mux.
    typedef enum logic [1:0] {
        LED_MODE_OFF     = 2'd0,
        LED_MODE_PATTERN = 2'd1,
        LED_MODE_WIN     = 2'd2,
        LED_MODE_LOSE    = 2'd3
    } led_mode_e;

endpackage

// File: rtl/simon_dwell_timer.sv
// Loadable down-counter that holds at zero; shared by the SHOW and GAP phases.
// Ports:
//   clk, rst    - clock, synchronous active-high reset
//   load        - load load_value this cycle (overrides decrement)
//   load_value  - value loaded into the counter
//   zero_c      - counter currently equals zero
module simon_dwell_timer #(
    parameter int unsigned TIMER_W = 24
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic [TIMER_W-1:0] load_value,
    output logic               zero_c
);

    logic [TIMER_W-1:0] count;

    // Count down to zero and hold there until reloaded.
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (count != '0) begin
            count <= count - TIMER_W'(1);
        end
    end

    assign zero_c = (count == '0);

endmodule

// File: rtl/simon_playback_sequencer.sv
// Plays pattern memory entries 0..count-1 on the LEDs, each shown for
// ON_CYCLES followed by OFF_CYCLES of blank display, then pulses done.
// Ports:
//   clk, rst      - clock, synchronous active-high reset
//   start         - request playback of count entries (honoured in IDLE only)
//   abort         - abandon playback, back to IDLE without done
//   count         - number of entries, captured on an accepted start
//   mem_rd_en     - memory read strobe
//   mem_addr      - memory read address (current entry index)
//   mem_rd_data   - memory read data, valid one cycle after mem_rd_en
//   display_leds  - pattern LED drive, nonzero only while showing an entry
//   busy          - high whenever not IDLE
//   done          - one-cycle pulse on normal completion
module simon_playback_sequencer
    import simon_pkg::*;
#(
    parameter int unsigned ADDR_W     = SIMON_ADDR_W,
    parameter int unsigned DATA_W     = SIMON_DATA_W,
    parameter int unsigned ON_CYCLES  = 12500000,
    parameter int unsigned OFF_CYCLES = 2500000,
    parameter int unsigned TIMER_W    = 24
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR_W-1:0] count,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_rd_data,
    output logic [DATA_W-1:0] display_leds,
    output logic              busy,
    output logic              done
);

    localparam int unsigned IDX_W = ADDR_W + 1;

    play_state_e        state;
    logic [ADDR_W-1:0]  index;
    logic [ADDR_W-1:0]  count_q;
    logic [DATA_W-1:0]  pattern_q;

    logic               timer_load;
    logic [TIMER_W-1:0] timer_value;
    logic               timer_zero;
    logic               advance;
    logic               last_entry;

    // Timer is loaded with the ON dwell at the end of WAIT, and with the
    // OFF dwell when SHOW expires (only if a gap exists).
    always_comb begin
        timer_load  = 1'b0;
        timer_value = TIMER_W'(ON_CYCLES - 1);
        if (state == ST_WAIT) begin
            timer_load = 1'b1;
        end else if (state == ST_SHOW && timer_zero && OFF_CYCLES != 0) begin
            timer_load  = 1'b1;
            timer_value = TIMER_W'(OFF_CYCLES - 1);
        end
    end

    simon_dwell_timer #(
        .TIMER_W(TIMER_W)
    ) u_dwell_timer (
        .clk       (clk),
        .rst       (rst),
        .load      (timer_load),
        .load_value(timer_value),
        .zero_c    (timer_zero)
    );

    // Entry finished: end of GAP, or end of SHOW when there is no gap.
    assign advance = timer_zero &&
                     ((state == ST_SHOW && OFF_CYCLES == 0) || state == ST_GAP);

    // Extra bit keeps index+1 from wrapping when count_q is all ones.
    assign last_entry = ({1'b0, index} + IDX_W'(1)) == {1'b0, count_q};

    assign mem_addr = index;

    // Outputs are registered alongside the state so they line up with it.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_IDLE;
            index        <= '0;
            count_q      <= '0;
            pattern_q    <= '0;
            mem_rd_en    <= 1'b0;
            display_leds <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
        end else begin
            mem_rd_en    <= 1'b0;
            display_leds <= '0;
            done         <= 1'b0;
            busy         <= 1'b1;
            if (abort && state != ST_IDLE) begin
                state <= ST_IDLE;
                busy  <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        busy <= 1'b0;
                        if (start) begin
                            busy <= 1'b1;
                            if (count != '0) begin
                                count_q   <= count;
                                index     <= '0;
                                mem_rd_en <= 1'b1;
                                state     <= ST_FETCH;
                            end else begin
                                done  <= 1'b1;
                                state <= ST_FINISH;
                            end
                        end
                    end
                    ST_FETCH: state <= ST_WAIT;
                    ST_WAIT: begin
                        pattern_q    <= mem_rd_data;
                        display_leds <= mem_rd_data;
                        state        <= ST_SHOW;
                    end
                    ST_SHOW: begin
                        if (!timer_zero) begin
                            display_leds <= pattern_q;
                        end else if (OFF_CYCLES != 0) begin
                            state <= ST_GAP;
                        end
                    end
                    ST_GAP: ;
                    ST_FINISH: begin
                        busy  <= 1'b0;
                        state <= ST_IDLE;
                    end
                    default: begin
                        busy  <= 1'b0;
                        state <= ST_IDLE;
                    end
                endcase

                if (advance) begin
                    if (last_entry) begin
                        done  <= 1'b1;
                        state <= ST_FINISH;
                    end else begin
                        index     <= index + ADDR_W'(1);
                        mem_rd_en <= 1'b1;
                        state     <= ST_FETCH;
                    end
                end
            end
        end
    end

endmodule
